// File: rtl/cp0_int_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// cp0_int_ctrl_pkg
// Shared definitions for the CP0 timer/interrupt controller:
//   - CP0 register numbers decoded by mtc0/mfc0
//   - Status / Cause field positions
//   - interrupt exception code and FSM state encoding
//   - priority encoder used to pick the serviced IP bit
// ----------------------------------------------------------------------------
package cp0_int_ctrl_pkg;

    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // Status fields
    localparam int ST_IE    = 0;
    localparam int ST_EXL   = 1;
    localparam int ST_IM_LO = 8;

    // Cause fields
    localparam int CA_EXC_LO = 2;
    localparam int CA_IP_LO  = 8;
    localparam int CA_TI     = 30;

    // IP bit owned by the timer
    localparam int IP_TIMER = 7;

    localparam logic [4:0] EXC_INT = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } cp0_state_t;

    // Index of the highest set bit; bit 7 (timer) has top priority.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// ----------------------------------------------------------------------------
// cp0_int_ctrl_if
// Pipeline <-> CP0 bus: mtc0/mfc0 register access, interrupt req/ack
// handshake and the ERET/EPC path.
//   master : pipeline side (drives writes, ack, epc_in, eret)
//   slave  : CP0 side (drives rdata, int_req, epc_out, int_code)
// ----------------------------------------------------------------------------
interface cp0_int_ctrl_if;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        int_req;
    logic        int_ack;
    logic [31:0] epc_in;
    logic        eret;
    logic [31:0] epc_out;
    logic [2:0]  int_code;

    modport master (
        output cp0_we, cp0_addr, cp0_wdata, int_ack, epc_in, eret,
        input  cp0_rdata, int_req, epc_out, int_code
    );

    modport slave (
        input  cp0_we, cp0_addr, cp0_wdata, int_ack, epc_in, eret,
        output cp0_rdata, int_req, epc_out, int_code
    );
endinterface

// File: rtl/cp0_int_ctrl_timer.sv
// ----------------------------------------------------------------------------
// cp0_int_ctrl_timer
// Count / Compare pair with prescaler and the sticky timer-pending bit.
//   clk, rst     clock, async active-high reset
//   count_we     mtc0 to Count this cycle
//   compare_we   mtc0 to Compare this cycle
//   wdata        mtc0 data
//   count        current Count
//   compare      current Compare
//   timer_pend   sticky IP[7]
// A register write always takes precedence over the same-cycle increment
// (Count) or match (Compare).
// ----------------------------------------------------------------------------
module cp0_int_ctrl_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_pend
);

    localparam int            PW      = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(COUNT_DIV - 1);

    logic [PW-1:0] prescaler_reg;
    logic [31:0]   count_reg;
    logic [31:0]   compare_reg;
    logic          pend_reg;
    logic          tick;

    // With COUNT_DIV=1 the prescaler stays at 0 == PRE_MAX, so every cycle ticks.
    assign tick = (prescaler_reg == PRE_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_reg <= '0;
            count_reg     <= 32'd0;
        end else if (count_we) begin
            prescaler_reg <= '0;
            count_reg     <= wdata;
        end else if (tick) begin
            prescaler_reg <= '0;
            count_reg     <= count_reg + 32'd1;
        end else begin
            prescaler_reg <= prescaler_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare_reg <= 32'hFFFF_FFFF;
            pend_reg    <= 1'b0;
        end else if (compare_we) begin
            compare_reg <= wdata;
            pend_reg    <= 1'b0;
        end else if (count_reg == compare_reg) begin
            pend_reg    <= 1'b1;
        end
    end

    assign count      = count_reg;
    assign compare    = compare_reg;
    assign timer_pend = pend_reg;

endmodule

// File: rtl/cp0_int_ctrl.sv
// ----------------------------------------------------------------------------
// cp0_int_ctrl
// CP0 timer/interrupt controller: Count/Compare timer, Status, Cause, EPC,
// hw_int synchroniser, interrupt priority and the req/ack/ERET sequencer.
//   clk, rst   clock, async active-high reset
//   hw_int     async level interrupt lines -> Cause.IP[6:2]
//   bus        slave side of cp0_int_ctrl_if (mtc0/mfc0, int_req/int_ack,
//              epc_in/epc_out, eret, int_code)
// ----------------------------------------------------------------------------
module cp0_int_ctrl
    import cp0_int_ctrl_pkg::*;
#(
    parameter int NUM_HW_INT  = 5,
    parameter int COUNT_DIV   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_HW_INT-1:0] hw_int,
    cp0_int_ctrl_if.slave         bus
);

    // ---------------- write decode ----------------
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    assign wr_count   = bus.cp0_we && (bus.cp0_addr == CP0_COUNT);
    assign wr_compare = bus.cp0_we && (bus.cp0_addr == CP0_COMPARE);
    assign wr_status  = bus.cp0_we && (bus.cp0_addr == CP0_STATUS);
    assign wr_cause   = bus.cp0_we && (bus.cp0_addr == CP0_CAUSE);
    assign wr_epc     = bus.cp0_we && (bus.cp0_addr == CP0_EPC);

    // ---------------- timer ----------------
    logic [31:0] count, compare;
    logic        timer_pend;

    cp0_int_ctrl_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr_count),
        .compare_we (wr_compare),
        .wdata      (bus.cp0_wdata),
        .count      (count),
        .compare    (compare),
        .timer_pend (timer_pend)
    );

    // ---------------- hw_int synchroniser ----------------
    logic [NUM_HW_INT-1:0] sync_reg [SYNC_STAGES];

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk or posedge rst) begin
                if (rst) sync_reg[gi] <= '0;
                else if (gi == 0) sync_reg[gi] <= hw_int;
                else sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    endgenerate

    // Map lines onto IP[6:2]; absent lines read as 0.
    logic [4:0] hw_ip;
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_hw_ip
            if (gi < NUM_HW_INT) begin : g_line
                assign hw_ip[gi] = sync_reg[SYNC_STAGES-1][gi];
            end else begin : g_zero
                assign hw_ip[gi] = 1'b0;
            end
        end
    endgenerate

    // ---------------- Status / Cause ----------------
    logic       ie_reg, exl_reg;
    logic [7:0] im_reg;
    logic [1:0] ip_sw_reg;
    logic [4:0] exc_code_reg;
    cp0_state_t state_reg;

    logic [7:0] ip, pend;
    logic       eligible, ack;

    assign ip       = {timer_pend, hw_ip, ip_sw_reg};
    assign pend     = ip & im_reg;
    assign eligible = (|pend) && ie_reg && !exl_reg;
    assign ack      = (state_reg == ST_REQ) && bus.int_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ie_reg       <= 1'b0;
            exl_reg      <= 1'b0;
            im_reg       <= 8'h00;
            ip_sw_reg    <= 2'b00;
            exc_code_reg <= 5'd0;
        end else begin
            if (wr_status) begin
                ie_reg <= bus.cp0_wdata[ST_IE];
                im_reg <= bus.cp0_wdata[ST_IM_LO +: 8];
            end
            // EXL priority: exception entry, then ERET, then software write.
            if (ack)            exl_reg <= 1'b1;
            else if (bus.eret)  exl_reg <= 1'b0;
            else if (wr_status) exl_reg <= bus.cp0_wdata[ST_EXL];

            if (wr_cause) ip_sw_reg <= bus.cp0_wdata[CA_IP_LO +: 2];
            if (ack)      exc_code_reg <= EXC_INT;
        end
    end

    // ---------------- request sequencer ----------------
    logic        int_req_reg;
    logic [31:0] epc_reg;
    logic [2:0]  int_code_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            int_req_reg  <= 1'b0;
            epc_reg      <= 32'd0;
            int_code_reg <= 3'd0;
        end else begin
            // Software EPC write; overridden below by a same-cycle ack.
            if (wr_epc) epc_reg <= bus.cp0_wdata;

            case (state_reg)
                ST_IDLE: begin
                    if (eligible) begin
                        state_reg   <= ST_REQ;
                        int_req_reg <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (bus.int_ack) begin
                        state_reg    <= ST_SERVICE;
                        int_req_reg  <= 1'b0;
                        epc_reg      <= bus.epc_in;
                        int_code_reg <= prio_enc(pend);
                    end else if (!eligible) begin
                        // Source went away before the pipeline took it.
                        state_reg   <= ST_IDLE;
                        int_req_reg <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (bus.eret) state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg   <= ST_IDLE;
                    int_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_req  = int_req_reg;
    assign bus.epc_out  = epc_reg;
    assign bus.int_code = int_code_reg;

    // ---------------- mfc0 read mux ----------------
    always_comb begin
        bus.cp0_rdata = 32'd0;
        case (bus.cp0_addr)
            CP0_COUNT:   bus.cp0_rdata = count;
            CP0_COMPARE: bus.cp0_rdata = compare;
            CP0_STATUS: begin
                bus.cp0_rdata[ST_IE]         = ie_reg;
                bus.cp0_rdata[ST_EXL]        = exl_reg;
                bus.cp0_rdata[ST_IM_LO +: 8] = im_reg;
            end
            CP0_CAUSE: begin
                bus.cp0_rdata[CA_TI]          = ip[IP_TIMER];
                bus.cp0_rdata[CA_IP_LO +: 8]  = ip;
                bus.cp0_rdata[CA_EXC_LO +: 5] = exc_code_reg;
            end
            CP0_EPC:     bus.cp0_rdata = epc_reg;
            default:     bus.cp0_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cp0_int_ctrl
// Directed stimulus for cp0_int_ctrl. Stimulus pushes expected values into a
// queue; a monitor on the falling edge pops each entry and compares it with
// the DUT output it names (mfc0 data, int_req, int_code or epc_out).
// ----------------------------------------------------------------------------
module tb_cp0_int_ctrl;

    localparam int K_REG  = 0;
    localparam int K_REQ  = 1;
    localparam int K_CODE = 2;
    localparam int K_EPC  = 3;

    localparam logic [4:0] A_COUNT   = 5'd9;
    localparam logic [4:0] A_COMPARE = 5'd11;
    localparam logic [4:0] A_STATUS  = 5'd12;
    localparam logic [4:0] A_CAUSE   = 5'd13;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] exp;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] hw_int;

    cp0_int_ctrl_if bus ();

    cp0_int_ctrl #(.NUM_HW_INT(5), .COUNT_DIV(2), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .hw_int (hw_int),
        .bus    (bus)
    );

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_REG:   act = bus.cp0_rdata;
                K_REQ:   act = {31'd0, bus.int_req};
                K_CODE:  act = {29'd0, bus.int_code};
                default: act = bus.epc_out;
            endcase
            tests_run++;
            if (act !== e.exp) begin
                tests_failed++;
                $display("[TB] FAIL %s: got %08h expected %08h", e.name, act, e.exp);
            end else begin
                $display("[TB] ok   %s = %08h", e.name, act);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_we    = 1'b1;
        bus.cp0_addr  = addr;
        bus.cp0_wdata = data;
        tick();
        bus.cp0_we    = 1'b0;
    endtask

    task automatic expect_sig(input int kind, input string name, input logic [31:0] exp);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    // Reads one register in the current cycle, then advances a cycle.
    task automatic expect_reg(input string name, input logic [4:0] addr, input logic [31:0] exp);
        bus.cp0_addr = addr;
        expect_sig(K_REG, name, exp);
        tick();
    endtask

    task automatic ack(input logic [31:0] pc);
        bus.epc_in  = pc;
        bus.int_ack = 1'b1;
        tick();
        bus.int_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b1;
        hw_int        = 5'd0;
        bus.cp0_we    = 1'b0;
        bus.cp0_addr  = 5'd0;
        bus.cp0_wdata = 32'd0;
        bus.int_ack   = 1'b0;
        bus.epc_in    = 32'd0;
        bus.eret      = 1'b0;
        tick();
        tick();

        // 1: reset values
        expect_sig(K_REQ, "rst_int_req", 32'd0);
        expect_reg("rst_count",   A_COUNT,   32'd0);
        expect_reg("rst_compare", A_COMPARE, 32'hFFFF_FFFF);
        expect_reg("rst_status",  A_STATUS,  32'd0);
        expect_reg("rst_cause",   A_CAUSE,   32'd0);
        rst = 1'b0;
        tick();

        // 2: timer interrupt, ack, eret, Compare rewrite
        wr(A_COMPARE, 32'd20);
        wr(A_STATUS,  32'h0000_8001);
        wr(A_COUNT,   32'd18);
        expect_reg("cnt18_a", A_COUNT, 32'd18);
        expect_reg("cnt18_b", A_COUNT, 32'd18);
        expect_reg("cnt19_a", A_COUNT, 32'd19);
        expect_sig(K_REQ, "tmr_req_n3", 32'd0);
        expect_reg("cnt19_b", A_COUNT, 32'd19);
        expect_sig(K_REQ, "tmr_req_n2", 32'd0);
        expect_reg("cnt20",   A_COUNT, 32'd20);
        expect_sig(K_REQ, "tmr_req_n1", 32'd0);
        expect_reg("cause_ip7", A_CAUSE, 32'h4000_8000);
        expect_sig(K_REQ, "tmr_req", 32'd1);
        ack(32'h0040_0010);
        expect_sig(K_REQ,  "tmr_req_after_ack", 32'd0);
        expect_sig(K_CODE, "tmr_code", 32'd7);
        expect_sig(K_EPC,  "tmr_epc", 32'h0040_0010);
        expect_reg("tmr_status_exl", A_STATUS, 32'h0000_8003);
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        expect_reg("eret_status", A_STATUS, 32'h0000_8001);
        expect_sig(K_REQ, "eret_rereq", 32'd1);
        wr(A_COMPARE, 32'd100);
        tick();
        expect_sig(K_REQ, "cmp_clear_req", 32'd0);
        expect_reg("cmp_clear_cause", A_CAUSE, 32'd0);

        // 3: hw_int[0] latency and withdrawal before ack
        wr(A_STATUS, 32'h0000_0401);
        hw_int[0] = 1'b1;
        expect_sig(K_REQ, "hw_req_e0", 32'd0);
        tick();
        expect_sig(K_REQ, "hw_req_e1", 32'd0);
        expect_reg("hw_cause_e1", A_CAUSE, 32'd0);
        expect_sig(K_REQ, "hw_req_e2", 32'd0);
        expect_reg("hw_cause_e2", A_CAUSE, 32'h0000_0400);
        expect_sig(K_REQ, "hw_req_e3", 32'd1);
        tick();
        hw_int[0] = 1'b0;
        tick();
        tick();
        expect_sig(K_REQ, "hw_req_hold", 32'd1);
        tick();
        expect_sig(K_REQ, "hw_req_drop", 32'd0);
        expect_sig(K_EPC, "hw_epc_kept", 32'h0040_0010);
        tick();

        // 4: priority and masking
        wr(A_STATUS, 32'h0000_8400);
        hw_int[0] = 1'b1;
        wr(A_COUNT,   32'd50);
        wr(A_COMPARE, 32'd50);
        tick();
        tick();
        expect_sig(K_REQ, "mask_ie0_req", 32'd0);
        expect_reg("prio_cause", A_CAUSE, 32'h4000_8400);
        wr(A_STATUS, 32'h0000_8403);
        expect_sig(K_REQ, "mask_exl_req_a", 32'd0);
        tick();
        expect_sig(K_REQ, "mask_exl_req_b", 32'd0);
        tick();
        wr(A_STATUS, 32'h0000_8401);
        tick();
        expect_sig(K_REQ, "prio_req", 32'd1);
        ack(32'h0040_0020);
        expect_sig(K_CODE, "prio_code7", 32'd7);
        expect_sig(K_EPC,  "prio_epc", 32'h0040_0020);
        expect_sig(K_REQ,  "prio_req_after_ack", 32'd0);
        tick();
        bus.eret = 1'b1;
        tick();
        bus.eret = 1'b0;
        wr(A_STATUS,  32'h0000_0400);
        wr(A_COMPARE, 32'd1000);
        wr(A_STATUS,  32'h0000_0401);
        tick();
        expect_sig(K_REQ, "ip2_req", 32'd1);
        ack(32'h0040_0030);
        expect_sig(K_CODE, "ip2_code2", 32'd2);
        expect_sig(K_EPC,  "ip2_epc", 32'h0040_0030);
        tick();
        // eret together with a Status write that tries to set EXL
        bus.eret = 1'b1;
        wr(A_STATUS, 32'h0000_0002);
        bus.eret = 1'b0;
        hw_int[0] = 1'b0;
        expect_sig(K_REQ, "eret_wr_req", 32'd0);
        expect_reg("eret_wr_status", A_STATUS, 32'd0);

        // 5: Count wrap and write-over-increment
        wr(A_COUNT, 32'hFFFF_FFFF);
        expect_reg("wrap_ff_a", A_COUNT, 32'hFFFF_FFFF);
        expect_reg("wrap_ff_b", A_COUNT, 32'hFFFF_FFFF);
        expect_reg("wrap_zero", A_COUNT, 32'd0);
        wr(A_COUNT, 32'h1234_5678);
        expect_reg("cnt_wr_a",  A_COUNT, 32'h1234_5678);
        expect_reg("cnt_wr_b",  A_COUNT, 32'h1234_5678);
        expect_reg("cnt_wr_inc", A_COUNT, 32'h1234_5679);

        // 6: reset while requesting
        wr(A_STATUS, 32'h0000_0401);
        hw_int[0] = 1'b1;
        tick();
        tick();
        tick();
        expect_sig(K_REQ, "pre_rst_req", 32'd1);
        tick();
        rst = 1'b1;
        #1;
        hw_int[0] = 1'b0;
        expect_sig(K_REQ, "rst_req_immediate", 32'd0);
        expect_reg("rst_req_compare", A_COMPARE, 32'hFFFF_FFFF);
        rst = 1'b0;
        tick();
        tick();
        tick();
        tick();
        expect_sig(K_REQ, "post_rst_req", 32'd0);
        expect_reg("post_rst_status", A_STATUS, 32'd0);

        tick();
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
